// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: a three-slot writer scoreboard drives stall,
// bubble and flush decisions for a five-stage in-order pipeline.
module hazard_ctrl #(
    parameter int ARQ = 16,
    parameter int RW  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [2:0]    id_opcode,
    input  logic [RW-1:0] id_rd,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic          ex_jump_taken,
    input  logic          mem_req,
    input  logic          mem_ready,
    output logic          pc_en,
    output logic          if_id_en,
    output logic          id_ex_en,
    output logic          ex_mem_en,
    output logic          mem_wb_en,
    output logic          flush_if_id,
    output logic          flush_id_ex,
    output logic [1:0]    state,
    output logic [15:0]   stall_cycles
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HAZ   = 2'd1,
        FLUSH = 2'd2,
        MWAIT = 2'd3
    } action_t;

    action_t       act;
    action_t       state_q;
    logic          writer;
    logic          reader;
    logic          hazard;
    logic [2:0]    slot_v;
    logic [RW-1:0] slot_rd [3];
    logic          unused_arq;

    assign unused_arq = (ARQ > 0);

    always_comb begin
        writer = 1'b0;
        reader = 1'b0;
        case (id_opcode)
            3'b000:  writer = 1'b1;
            3'b001:  begin writer = 1'b1; reader = 1'b1; end
            3'b010:  begin writer = 1'b1; reader = 1'b1; end
            3'b011:  reader = 1'b1;
            3'b100:  reader = 1'b1;
            3'b111:  begin writer = 1'b1; reader = 1'b1; end
            default: ;
        endcase
    end

    // Slot 0 is EX, 1 is MEM, 2 is WB.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (slot_v[i] && (slot_rd[i] == id_rs1 || slot_rd[i] == id_rs2))
                hazard = 1'b1;
        end
        hazard = hazard && id_valid && reader;
    end

    always_comb begin
        if (mem_req && !mem_ready)
            act = MWAIT;
        else if (ex_jump_taken)
            act = FLUSH;
        else if (hazard)
            act = HAZ;
        else
            act = RUN;
    end

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
            mem_wb_en   = 1'b0;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else begin
            case (act)
                MWAIT: begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                    mem_wb_en = 1'b0;
                end
                FLUSH: begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end
                HAZ: begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    flush_id_ex = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_v       <= '0;
            state_q      <= RUN;
            stall_cycles <= '0;
        end else begin
            state_q <= act;
            if (act != RUN && stall_cycles != '1)
                stall_cycles <= stall_cycles + 16'd1;
            if (act != MWAIT) begin
                slot_v[2]  <= slot_v[1];
                slot_v[1]  <= slot_v[0];
                slot_v[0]  <= (act == RUN) && id_valid && writer;
                slot_rd[2] <= slot_rd[1];
                slot_rd[1] <= slot_rd[0];
                slot_rd[0] <= id_rd;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic against a list-of-writers-in-flight reference model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [2:0]  id_opcode = '0;
    logic [3:0]  id_rd = '0, id_rs1 = '0, id_rs2 = '0;
    logic        ex_jump_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        flush_if_id, flush_id_ex;
    logic [1:0]  state;
    logic [15:0] stall_cycles;

    int total = 0;
    int bad = 0;

    // Reference model: in-flight writer destinations, newest first; -1 = none.
    int inflight [3];
    int m_state;
    int m_stall;

    hazard_ctrl #(.ARQ(16), .RW(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_jump_taken(ex_jump_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .state(state), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_writer(input int op);
        return op inside {0, 1, 2, 7};
    endfunction

    function automatic bit is_reader(input int op);
        return op inside {1, 2, 3, 4, 7};
    endfunction

    function automatic int model_action();
        bit haz = 1'b0;
        if (mem_req && !mem_ready) return 3;
        if (ex_jump_taken) return 2;
        foreach (inflight[i])
            if (inflight[i] >= 0 && (inflight[i] == int'(id_rs1) || inflight[i] == int'(id_rs2)))
                haz = 1'b1;
        if (haz && id_valid && is_reader(int'(id_opcode))) return 1;
        return 0;
    endfunction

    // {pc, if_id, id_ex, ex_mem, mem_wb, flush_if_id, flush_id_ex}
    function automatic int expected_ctl(input int act);
        if (rst) return 7'b0000011;
        case (act)
            0:       return 7'b1111100;
            1:       return 7'b0011101;
            2:       return 7'b1111111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int ctl_word();
        return int'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, flush_if_id, flush_id_ex});
    endfunction

    task automatic model_clock(input int act);
        if (rst) begin
            foreach (inflight[i]) inflight[i] = -1;
            m_state = 0;
            m_stall = 0;
        end else begin
            m_state = act;
            if (act != 0 && m_stall < 65535) m_stall++;
            if (act != 3) begin
                inflight[2] = inflight[1];
                inflight[1] = inflight[0];
                inflight[0] = (act == 0 && id_valid && is_writer(int'(id_opcode))) ? int'(id_rd) : -1;
            end
        end
    endtask

    // Drive one cycle, check the combinational controls, clock, check registers.
    task automatic cycle(input bit r, input bit v, input int op, input int rd, input int s1,
                         input int s2, input bit jt, input bit mq, input bit mr);
        int act;
        rst = r; id_valid = v; id_opcode = 3'(op); id_rd = 4'(rd);
        id_rs1 = 4'(s1); id_rs2 = 4'(s2);
        ex_jump_taken = jt; mem_req = mq; mem_ready = mr;
        #1;
        act = model_action();
        check("ctl", ctl_word(), expected_ctl(act));
        @(posedge clk);
        model_clock(act);
        #1;
        check("state", int'(state), m_state);
        check("stall", int'(stall_cycles), m_stall);
    endtask

    task automatic idle(input bit r);
        cycle(r, 0, 5, 0, 0, 0, 0, 0, 0);
    endtask

    int base;

    initial begin
        foreach (inflight[i]) inflight[i] = -1;
        m_state = 0;
        m_stall = 0;

        // Reset state
        idle(1);
        check("rst_state", int'(state), 0);
        check("rst_stall", int'(stall_cycles), 0);

        // Back-to-back RAW: ADD r3 then MODEX r3
        cycle(0, 1, 1, 3, 0, 0, 0, 0, 0);
        check("raw_add_run", int'(state), 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 3, 0, 3, 9, 0, 0, 0);
            check("raw_haz_state", int'(state), 1);
        end
        cycle(0, 1, 3, 0, 3, 9, 0, 0, 0);
        check("raw_resume", int'(state), 0);
        check("raw_stall3", int'(stall_cycles), 3);

        // Independent: SET r2 then CMPEQ r4,r5
        idle(1);
        cycle(0, 1, 0, 2, 0, 0, 0, 0, 0);
        cycle(0, 1, 4, 0, 4, 5, 0, 0, 0);
        check("indep_ctl", ctl_word(), 7'b1111100);
        check("indep_stall", int'(stall_cycles), 0);

        // Taken jump over a hazarding reader, then the same reader again
        cycle(0, 1, 1, 5, 0, 0, 0, 0, 0);
        cycle(0, 1, 3, 0, 5, 5, 1, 0, 0);
        check("jump_state", int'(state), 2);
        cycle(0, 1, 3, 0, 6, 6, 0, 0, 0);
        check("jump_ex_cleared", int'(state), 0);

        // Memory wait with pending jump, then release
        cycle(0, 1, 1, 8, 0, 0, 0, 0, 0);
        base = int'(stall_cycles);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 3, 0, 8, 8, 1, 1, 0);
            check("mwait_state", int'(state), 3);
        end
        cycle(0, 1, 3, 0, 8, 8, 1, 1, 1);
        check("mwait_flush", int'(state), 2);
        check("mwait_stall5", int'(stall_cycles), base + 5);

        // Reset during the second HAZ cycle
        idle(1);
        cycle(0, 1, 1, 7, 0, 0, 0, 0, 0);
        cycle(0, 1, 2, 1, 7, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check("rst_midhaz_ctl", ctl_word(), 7'b0000011);
        cycle(1, 1, 2, 1, 7, 0, 0, 0, 0);
        cycle(0, 1, 2, 1, 7, 0, 0, 0, 0);
        check("post_rst_state", int'(state), 0);
        check("post_rst_stall", int'(stall_cycles), 0);

        // Randomized traffic, small register range to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            bit mq;
            mq = ($urandom_range(3) == 0);
            cycle(($urandom_range(63) == 0), ($urandom_range(3) != 0), $urandom_range(7),
                  $urandom_range(3), $urandom_range(3), $urandom_range(3),
                  ($urandom_range(7) == 0), mq, mq ? $urandom_range(1) : 1'b0);
        end

        // Counter saturation over a long memory wait
        idle(1);
        rst = 1'b0; mem_req = 1'b1; mem_ready = 1'b0; ex_jump_taken = 1'b0;
        repeat (70000) begin
            @(posedge clk);
            model_clock(3);
        end
        #1;
        check("sat_stall", int'(stall_cycles), 16'hFFFF);
        check("sat_model", int'(stall_cycles), m_stall);
        check("sat_ctl", ctl_word(), 7'b0000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter ARQ, default 16, giving the datapath word width; it is informational only, because no port depends on it.
REQ-002 SHALL have parameter RW, default 4, giving the register-index width (16 registers).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port id_valid, input, 1 bit: the ID stage holds a real instruction.
REQ-006 SHALL have port id_opcode, input, 3 bits: the opcode of the ID instruction.
REQ-007 SHALL have port id_rd, input, RW bits: the destination register of the ID instruction.
REQ-008 SHALL have ports id_rs1 and id_rs2, input, RW bits each: the source registers of the ID instruction.
REQ-009 SHALL have port ex_jump_taken, input, 1 bit: the EXE stage holds a taken J or JEQ.
REQ-010 SHALL have port mem_req, input, 1 bit: the MEM stage holds a load (LDPX) or store (STPX).
REQ-011 SHALL have port mem_ready, input, 1 bit: data memory completes the access this cycle.
REQ-012 SHALL have ports pc_en, if_id_en, id_ex_en, ex_mem_en and mem_wb_en, output, 1 bit each: the stage-register enables.
REQ-013 SHALL have ports flush_if_id and flush_id_ex, output, 1 bit each: load a bubble into that stage register.
REQ-014 SHALL have port state, output, 2 bits: the action taken last cycle (0 RUN, 1 HAZ, 2 FLUSH, 3 MWAIT).
REQ-015 SHALL have port stall_cycles, output, 16 bits: a saturating count of non-RUN cycles.

Function
REQ-016 Decode SHALL classify opcodes as follows:
- writer: 000, 001, 010, 111;
- reader (uses both id_rs1 and id_rs2): 001, 010, 011, 100, 111;
- all other opcodes neither read nor write.
REQ-017 Scoreboard SHALL hold three slots (EX, MEM, WB), each a valid bit plus an RW-bit register index, mirroring writers in flight; there is no forwarding and no register-file write-before-read.
REQ-018 A hazard SHALL be flagged when all of the following hold:
- id_valid=1;
- the ID instruction is a reader;
- id_rs1 or id_rs2 equals the index of any valid slot.
REQ-019 Actions SHALL be evaluated combinationally each cycle in this priority order: MWAIT > FLUSH > HAZ > RUN.
REQ-020 MWAIT (mem_req=1 and mem_ready=0) SHALL drive:
- all five enables = 0 and both flushes = 0;
- scoreboard held;
- ex_jump_taken ignored, to be acted on once the freeze lifts.
REQ-021 FLUSH (ex_jump_taken=1, not MWAIT) SHALL drive:
- all enables = 1;
- flush_if_id = 1 and flush_id_ex = 1;
- the hazard check suppressed.
REQ-022 HAZ (not MWAIT/FLUSH) SHALL drive:
- pc_en = 0 and if_id_en = 0;
- id_ex_en = 1 with flush_id_ex = 1 (bubble inserted);
- ex_mem_en = 1 and mem_wb_en = 1;
- flush_if_id = 0.
REQ-023 RUN SHALL drive all enables = 1 and both flushes = 0.
REQ-024 Scoreboard shift SHALL occur on every non-MWAIT cycle:
- WB receives MEM, and MEM receives EX;
- EX receives {1, id_rd} only in RUN with id_valid=1 and a writer in ID, and receives invalid otherwise.
REQ-025 Register 0 SHALL NOT be special: a writer to register 0 is tracked like any other register.
REQ-026 Output latency SHALL be 0 cycles: the enables and flushes are combinational from the inputs and the scoreboard.
REQ-027 The state output SHALL register the action of each cycle and present it in the following cycle.
REQ-028 stall_cycles SHALL increment by 1 for each cycle whose action is not RUN, and SHALL hold at 0xFFFF once it reaches that value.
REQ-029 A hazard SHALL clear without extra delay: RUN resumes in the first cycle in which no valid slot matches, with a maximum of 3 consecutive HAZ cycles per instruction.
REQ-030 mem_ready=1 while mem_req=1 SHALL count as a normal cycle, not MWAIT.

Reset
REQ-031 On rst=1 at a clock edge, the block SHALL:
- clear all slot valid bits;
- set state = 0;
- set stall_cycles = 0.
REQ-032 While rst=1, outputs SHALL be all enables = 0, flush_if_id = 1 and flush_id_ex = 1, regardless of the other inputs.
REQ-033 Reset asserted mid-stall or mid-MWAIT SHALL abandon that action; the first cycle after rst falls SHALL evaluate from the empty scoreboard.

Verification
REQ-034 The bench SHALL cover back-to-back RAW:
- stimulus: ADD r3 in ID (RUN), then MODEX reading r3 in ID;
- response: 3 cycles of pc_en=0 and flush_id_ex=1, then RUN;
- response: stall_cycles = 3, and the state output shows 1,1,1,0.
REQ-035 The bench SHALL cover an independent instruction:
- stimulus: SET r2, then CMPEQ r4,r5;
- response: no stall, and all enables = 1 throughout.
REQ-036 The bench SHALL cover a taken jump:
- stimulus: ex_jump_taken=1 for 1 cycle, with a hazarding reader in ID;
- response: flush_if_id=1, flush_id_ex=1 and pc_en=1; the hazard is ignored and the EX slot becomes invalid.
REQ-037 The bench SHALL cover a memory wait:
- stimulus: mem_req=1 with mem_ready=0 for 4 cycles while ex_jump_taken=1;
- response: all enables = 0 for 4 cycles, and the scoreboard is unchanged;
- response: in the 5th cycle FLUSH occurs and stall_cycles increases by 5.
REQ-038 The bench SHALL cover the counter saturating:
- stimulus: force 70000 MWAIT cycles;
- response: stall_cycles holds at 0xFFFF.
REQ-039 The bench SHALL cover reset mid-hazard:
- stimulus: assert rst during the 2nd HAZ cycle;
- response: while rst=1, all enables = 0 and both flushes = 1;
- response: after release, the same reader in ID proceeds with no stall and state = 0.
